t03_horizontal_timing: RTL and testbench

Horizontal timing stage of the team_03 display path. Counts pixel positions within a scan line, walks an ACTIVE/FRONT_PORCH/SYNC/BACK_PORCH phase machine, and drives hsync and horizontal blanking. Emits a one-cycle line terminal-count pulse `tc` that feeds `tc` of the downstream vertical counter. Defaults implement 800x600@72 Hz horizontal timing (1040 pixels/line, 50 MHz pixel rate), matching the vertical counter's 666-line frame.

---
 rtl/t03_display_pkg.sv | 39 +++
 rtl/t03_horizontal_timing_if.sv | 23 ++
 rtl/t03_horizontal_timing.sv | 80 ++++++++
 tb/tb_t03_horizontal_timing.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/t03_display_pkg.sv
// Shared display-path types and default 800x600@72 Hz timing constants.
// Provides the horizontal phase enum and the phase-length lookup.
package t03_display_pkg;

    localparam int CNT_W = 11;

    // 800x600@72 Hz, 50 MHz pixel clock: 1040 pixels x 666 lines
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 56;
    localparam int H_SYNC_DEF   = 120;
    localparam int H_BP_DEF     = 64;

    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 37;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 23;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } h_phase_t;

    // Last offset (length-1) of a phase
    function automatic logic [CNT_W-1:0] phase_last(
        h_phase_t p, int a, int fp, int s, int bp);
        int n;
        n = a;
        unique case (p)
            PH_ACTIVE: n = a;
            PH_FP:     n = fp;
            PH_SYNC:   n = s;
            PH_BP:     n = bp;
        endcase
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/t03_horizontal_timing_if.sv
// Horizontal timing bundle: pixel strobe/clear in, position and sync out.
// master = consumer/driver of en and clear, slave = timing generator.
interface t03_horizontal_timing_if;
    import t03_display_pkg::*;

    logic             en;
    logic             clear;
    logic [CNT_W-1:0] Hcnt;
    logic             tc;
    logic             hsync;
    logic             h_active;
    h_phase_t         h_phase;

    modport master (
        output en, clear,
        input  Hcnt, tc, hsync, h_active, h_phase
    );

    modport slave (
        input  en, clear,
        output Hcnt, tc, hsync, h_active, h_phase
    );
endinterface

// File: rtl/t03_horizontal_timing.sv
// Horizontal timing stage: pixel counter, phase FSM, hsync/blank, line tc.
// Ports: clk, nrst (sync active-low), bus (slave: en/clear in, Hcnt/tc/hsync/h_active/h_phase out).
module t03_horizontal_timing
    import t03_display_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter logic HSYNC_POL = 1'b1
) (
    input  logic                    clk,
    input  logic                    nrst,
    t03_horizontal_timing_if.slave  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

    if (H_TOTAL > 2047 || H_ACTIVE < 1 || H_FP < 1 ||
        H_SYNC < 1 || H_BP < 1) begin : g_bad_cfg
        $error("t03_horizontal_timing: illegal horizontal timing");
    end

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    h_phase_t         state_q, state_d;
    logic             hsync_q, hsync_d;
    logic             h_active_q, h_active_d;

    always_comb begin
        hcnt_d      = hcnt_q;
        phase_cnt_d = phase_cnt_q;
        state_d     = state_q;
        hsync_d     = hsync_q;
        h_active_d  = h_active_q;
        if (bus.clear) begin
            hcnt_d      = '0;
            phase_cnt_d = '0;
            state_d     = PH_ACTIVE;
            hsync_d     = ~HSYNC_POL;
            h_active_d  = 1'b1;
        end else if (bus.en) begin
            hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
            if (phase_cnt_q == phase_last(state_q, H_ACTIVE, H_FP,
                                          H_SYNC, H_BP)) begin
                phase_cnt_d = '0;
                state_d     = h_phase_t'(state_q + 2'd1);
            end else begin
                phase_cnt_d = phase_cnt_q + 1'b1;
            end
            // Decoded from next state so outputs line up with Hcnt
            hsync_d    = (state_d == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            h_active_d = (state_d == PH_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            hcnt_q      <= '0;
            phase_cnt_q <= '0;
            state_q     <= PH_ACTIVE;
            hsync_q     <= ~HSYNC_POL;
            h_active_q  <= 1'b1;
        end else begin
            hcnt_q      <= hcnt_d;
            phase_cnt_q <= phase_cnt_d;
            state_q     <= state_d;
            hsync_q     <= hsync_d;
            h_active_q  <= h_active_d;
        end
    end

    assign bus.Hcnt     = hcnt_q;
    assign bus.tc       = (hcnt_q == H_LAST) && bus.en && !bus.clear;
    assign bus.hsync    = hsync_q;
    assign bus.h_active = h_active_q;
    assign bus.h_phase  = state_q;

endmodule

// File: tb/tb_t03_horizontal_timing.sv
// Directed bench for t03_horizontal_timing: default 1040-pixel line and
// a 4/1/2/1 instance, with en gating, clear and mid-line reset.
module tb_t03_horizontal_timing;
    import t03_display_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tc_seen;
    int   h;

    always #5 clk = ~clk;

    t03_horizontal_timing_if ifa ();
    t03_horizontal_timing_if ifb ();

    t03_horizontal_timing dut_a (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifa)
    );

    t03_horizontal_timing #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1)
    ) dut_b (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifb)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_phase(int x, int a, int fp, int s);
        if (x < a) return 0;
        if (x < a + fp) return 1;
        if (x < a + fp + s) return 2;
        return 3;
    endfunction

    // Full output check of the default instance at position x
    task automatic chk_a(int x);
        chk("a.Hcnt", 32'(ifa.Hcnt), 32'(x));
        chk("a.hsync", 32'(ifa.hsync), 32'(x >= 856 && x <= 975));
        chk("a.h_active", 32'(ifa.h_active), 32'(x < 800));
        chk("a.h_phase", 32'(ifa.h_phase), 32'(exp_phase(x, 800, 56, 120)));
        chk("a.tc", 32'(ifa.tc),
            32'(ifa.en && !ifa.clear && x == 1039));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.en = 1'b0;
        ifa.clear = 1'b0;
        ifb.en = 1'b0;
        ifb.clear = 1'b0;
        nrst = 1'b0;
        tick();
        tick();
        chk_a(0);
        chk("b.Hcnt.rst", 32'(ifb.Hcnt), 32'd0);
        chk("b.hsync.rst", 32'(ifb.hsync), 32'd0);

        // Free run: two full lines plus a bit
        nrst = 1'b1;
        ifa.en = 1'b1;
        h = 0;
        tc_seen = 0;
        for (int i = 0; i < 2100; i++) begin
            chk_a(h);
            if (ifa.tc) tc_seen++;
            tick();
            h = (h + 1) % 1040;
        end
        chk("a.tc_count_run", 32'(tc_seen), 32'd2);
        chk("b.hold_en0", 32'(ifb.Hcnt), 32'd0);

        // en every other cycle: one line takes 2080 cycles
        tc_seen = 0;
        for (int i = 0; i < 2080; i++) begin
            ifa.en = (i % 2 == 0);
            #1;
            chk_a(h);
            if (ifa.tc) tc_seen++;
            tick();
            if (i % 2 == 0) h = (h + 1) % 1040;
        end
        chk("a.tc_count_toggle", 32'(tc_seen), 32'd1);
        chk("a.Hcnt_after_toggle", 32'(ifa.Hcnt), 32'd20);

        // Advance to 500, then clear mid-line
        ifa.en = 1'b1;
        while (h != 500) begin
            chk_a(h);
            tick();
            h = h + 1;
        end
        ifa.clear = 1'b1;
        #1;
        chk_a(500);
        tick();
        ifa.clear = 1'b0;
        h = 0;
        chk_a(0);

        // Clear coincident with the last pixel suppresses tc
        while (h != 1039) begin
            chk_a(h);
            tick();
            h = h + 1;
        end
        ifa.clear = 1'b1;
        #1;
        chk("a.tc_clear_last", 32'(ifa.tc), 32'd0);
        tick();
        ifa.clear = 1'b0;
        h = 0;
        chk_a(0);

        // Reset inside SYNC
        while (h != 900) begin
            chk_a(h);
            tick();
            h = h + 1;
        end
        chk("a.hsync_at900", 32'(ifa.hsync), 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        h = 0;
        chk_a(0);

        // Small instance: 4/1/2/1, period 8
        ifb.en = 1'b1;
        tc_seen = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("b.Hcnt", 32'(ifb.Hcnt), 32'(i % 8));
            chk("b.hsync", 32'(ifb.hsync),
                32'((i % 8) >= 5 && (i % 8) <= 6));
            chk("b.h_active", 32'(ifb.h_active), 32'((i % 8) < 4));
            chk("b.h_phase", 32'(ifb.h_phase),
                32'(exp_phase(i % 8, 4, 1, 2)));
            chk("b.tc", 32'(ifb.tc), 32'((i % 8) == 7));
            if (ifb.tc) tc_seen++;
            tick();
        end
        chk("b.tc_count", 32'(tc_seen), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
